// File: rtl/cache_controller.sv
// Two-line direct-mapped MSI cache controller on a snooping bus.
// The bus carries {estado, tag, valor} messages. Dirty lines that another
// cache read-misses are downgraded to S and flushed before new CPU work.
// Handshake: cpu_req is sampled only in IDLE. Each request ends with a single
// cpu_ready pulse. bus_req stays high from ARB through the last message cycle.
// A transaction advances past ARB only on an edge with bus_gnt=1.
module cache_controller #(
    parameter logic [1:0] Idle      = 2'b00,
    parameter logic [1:0] ReadMiss  = 2'b01,
    parameter logic [1:0] WriteMiss = 2'b10,
    parameter logic [1:0] WriteBack = 2'b11
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [2:0] cpu_addr,
    input  logic [3:0] cpu_wdata,
    output logic       cpu_ready,
    output logic [3:0] cpu_rdata,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [8:0] bus,
    input  logic [8:0] q,
    input  logic [8:0] snoop
);
    typedef enum logic [1:0] {LINE_I, LINE_S, LINE_M} line_st_e;
    typedef enum logic [2:0] {IDLE, ARB, WB, RM, WM, DONE} state_e;

    state_e     state_q, state_d;
    line_st_e   line_st_q [2];
    line_st_e   line_st_d [2];
    logic [2:0] line_tag_q [2];
    logic [2:0] line_tag_d [2];
    logic [3:0] line_data_q [2];
    logic [3:0] line_data_d [2];
    logic [1:0] flush_q, flush_d;
    logic       pend_q, pend_d;          // request accepted while a flush was due
    logic [2:0] addr_q, addr_d;
    logic       we_q, we_d;
    logic [3:0] wdata_q, wdata_d;
    logic       flush_op_q, flush_op_d;  // current bus transaction is a flush
    logic       flush_idx_q, flush_idx_d;
    logic       cpu_ready_q, cpu_ready_d;
    logic [3:0] cpu_rdata_q, cpu_rdata_d;

    logic       eff_req, eff_we, eff_idx, vic_idx;
    logic [2:0] eff_addr;
    logic [3:0] eff_wdata;
    logic       snp_idx;

    assign eff_req   = cpu_req | pend_q;
    assign eff_addr  = pend_q ? addr_q : cpu_addr;
    assign eff_we    = pend_q ? we_q : cpu_we;
    assign eff_wdata = pend_q ? wdata_q : cpu_wdata;
    assign eff_idx   = eff_addr[0];
    assign snp_idx   = snoop[4];
    assign vic_idx   = flush_op_q ? flush_idx_q : addr_q[0];

    // State, line array and request registers; reset aborts any transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < 2; i++) begin
                line_st_q[i]   <= LINE_I;
                line_tag_q[i]  <= 3'd0;
                line_data_q[i] <= 4'd0;
            end
            flush_q     <= 2'b00;
            pend_q      <= 1'b0;
            addr_q      <= 3'd0;
            we_q        <= 1'b0;
            wdata_q     <= 4'd0;
            flush_op_q  <= 1'b0;
            flush_idx_q <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < 2; i++) begin
                line_st_q[i]   <= line_st_d[i];
                line_tag_q[i]  <= line_tag_d[i];
                line_data_q[i] <= line_data_d[i];
            end
            flush_q     <= flush_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            flush_op_q  <= flush_op_d;
            flush_idx_q <= flush_idx_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // Snoop updates first, then CPU/FSM actions on the snoop-adjusted lines.
    always_comb begin
        state_d     = state_q;
        line_st_d   = line_st_q;
        line_tag_d  = line_tag_q;
        line_data_d = line_data_q;
        flush_d     = flush_q;
        pend_d      = pend_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        flush_op_d  = flush_op_q;
        flush_idx_d = flush_idx_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;

        if (line_tag_q[snp_idx] == snoop[6:4]) begin
            if (snoop[8:7] == WriteMiss && line_st_q[snp_idx] != LINE_I) begin
                line_st_d[snp_idx] = LINE_I;
            end else if (snoop[8:7] == ReadMiss && line_st_q[snp_idx] == LINE_M) begin
                line_st_d[snp_idx] = LINE_S;
                flush_d[snp_idx]   = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (flush_d != 2'b00) begin
                    state_d     = ARB;
                    flush_op_d  = 1'b1;
                    flush_idx_d = ~flush_d[0];
                    if (eff_req) begin
                        pend_d  = 1'b1;
                        addr_d  = eff_addr;
                        we_d    = eff_we;
                        wdata_d = eff_wdata;
                    end
                end else if (eff_req) begin
                    pend_d = 1'b0;
                    if (!eff_we && line_st_d[eff_idx] != LINE_I
                        && line_tag_q[eff_idx] == eff_addr) begin
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = line_data_q[eff_idx];
                    end else if (eff_we && line_st_d[eff_idx] == LINE_M
                                 && line_tag_q[eff_idx] == eff_addr) begin
                        line_data_d[eff_idx] = eff_wdata;
                        cpu_ready_d          = 1'b1;
                    end else begin
                        state_d    = ARB;
                        flush_op_d = 1'b0;
                        addr_d     = eff_addr;
                        we_d       = eff_we;
                        wdata_d    = eff_wdata;
                    end
                end
            end
            ARB: begin
                if (bus_gnt) begin
                    if (flush_op_q) begin
                        state_d = WB;
                    end else if ((line_st_d[addr_q[0]] == LINE_M || flush_d[addr_q[0]])
                                 && line_tag_q[addr_q[0]] != addr_q) begin
                        state_d = WB;
                    end else begin
                        state_d = we_q ? WM : RM;
                    end
                end
            end
            WB: begin
                flush_d[vic_idx] = 1'b0;
                if (flush_op_q) begin
                    state_d = IDLE;
                end else begin
                    line_st_d[vic_idx] = LINE_I;
                    state_d = we_q ? WM : RM;
                end
            end
            RM: begin
                line_st_d[addr_q[0]]   = LINE_S;
                line_tag_d[addr_q[0]]  = addr_q;
                line_data_d[addr_q[0]] = q[3:0];
                flush_d[addr_q[0]]     = 1'b0;
                cpu_rdata_d            = q[3:0];
                cpu_ready_d            = 1'b1;
                state_d                = DONE;
            end
            WM: begin
                line_st_d[addr_q[0]]   = LINE_M;
                line_tag_d[addr_q[0]]  = addr_q;
                line_data_d[addr_q[0]] = wdata_q;
                flush_d[addr_q[0]]     = 1'b0;
                cpu_ready_d            = 1'b1;
                state_d                = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus message and arbitration request decoded from the current state.
    always_comb begin
        bus     = {Idle, 3'b000, 4'b0000};
        bus_req = 1'b0;
        unique case (state_q)
            ARB: bus_req = 1'b1;
            WB: begin
                bus     = {WriteBack, line_tag_q[vic_idx], line_data_q[vic_idx]};
                bus_req = 1'b1;
            end
            RM: begin
                bus     = {ReadMiss, addr_q, 4'b0000};
                bus_req = 1'b1;
            end
            WM: begin
                bus     = {WriteMiss, addr_q, wdata_q};
                bus_req = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: misses, hits, write-back on eviction,
// snoop invalidate/flush, stalled arbitration and mid-transaction reset.
module tb_cache_controller;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_req, cpu_we;
    logic [2:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic       cpu_ready;
    logic [3:0] cpu_rdata;
    logic       bus_req, bus_gnt;
    logic [8:0] bus, q, snoop;
    logic [3:0] mem [8];

    int errors = 0;
    int checks = 0;

    cache_controller dut (
        .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .bus_req(bus_req), .bus_gnt(bus_gnt), .bus(bus),
        .q(q), .snoop(snoop)
    );

    // clock and memory model
    always #5 clock = ~clock;
    always_comb q = {2'b00, bus[6:4], mem[bus[6:4]]};

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one-cycle request pulse, sampled at the next rising edge
    task automatic request(input logic we, input logic [2:0] addr, input logic [3:0] wd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        tick(1);
        cpu_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'h0;
        mem[1] = 4'h3; mem[2] = 4'h6; mem[5] = 4'hA; mem[6] = 4'h9;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 3'd0;
        cpu_wdata = 4'd0; bus_gnt = 1'b1; snoop = 9'd0;
        #3;
        chk("rst_ready", {8'd0, cpu_ready}, 9'd0);
        chk("rst_rdata", {5'd0, cpu_rdata}, 9'd0);
        chk("rst_bus_req", {8'd0, bus_req}, 9'd0);
        chk("rst_bus", bus, 9'd0);
        #9 reset_n = 1'b1;
        tick(1);

        // read miss on address 5
        request(1'b0, 3'd5, 4'd0);
        chk("rm5_arb_req", {8'd0, bus_req}, 9'd1);
        chk("rm5_arb_bus", bus, 9'd0);
        tick(1);
        chk("rm5_bus", bus, 9'b01_101_0000);
        chk("rm5_bus_req", {8'd0, bus_req}, 9'd1);
        tick(1);
        chk("rm5_ready", {8'd0, cpu_ready}, 9'd1);
        chk("rm5_rdata", {5'd0, cpu_rdata}, 9'hA);
        chk("rm5_done_bus_req", {8'd0, bus_req}, 9'd0);
        chk("rm5_done_bus", bus, 9'd0);
        tick(1);
        chk("rm5_ready_drop", {8'd0, cpu_ready}, 9'd0);

        // two read hits on address 5
        for (int k = 0; k < 2; k++) begin
            request(1'b0, 3'd5, 4'd0);
            chk("hit5_ready", {8'd0, cpu_ready}, 9'd1);
            chk("hit5_rdata", {5'd0, cpu_rdata}, 9'hA);
            chk("hit5_bus_req", {8'd0, bus_req}, 9'd0);
            chk("hit5_bus", bus, 9'd0);
            tick(1);
        end

        // write miss on address 3, then read 1 evicts it
        request(1'b1, 3'd3, 4'h7);
        chk("wm3_arb_req", {8'd0, bus_req}, 9'd1);
        tick(1);
        chk("wm3_bus", bus, 9'b10_011_0111);
        tick(1);
        chk("wm3_ready", {8'd0, cpu_ready}, 9'd1);
        tick(1);
        request(1'b0, 3'd1, 4'd0);
        tick(1);
        chk("rd1_wb_bus", bus, 9'b11_011_0111);
        tick(1);
        chk("rd1_rm_bus", bus, 9'b01_001_0000);
        chk("rd1_rm_bus_req", {8'd0, bus_req}, 9'd1);
        tick(1);
        chk("rd1_ready", {8'd0, cpu_ready}, 9'd1);
        chk("rd1_rdata", {5'd0, cpu_rdata}, 9'h3);
        tick(1);

        // address 2 loaded shared, snoop write-miss invalidates it
        request(1'b0, 3'd2, 4'd0);
        tick(2);
        chk("rd2_ready", {8'd0, cpu_ready}, 9'd1);
        chk("rd2_rdata", {5'd0, cpu_rdata}, 9'h6);
        tick(1);
        snoop = 9'b10_010_0101;
        tick(1);
        snoop = 9'd0;
        request(1'b0, 3'd2, 4'd0);
        chk("rd2_again_no_hit", {8'd0, cpu_ready}, 9'd0);
        chk("rd2_again_arb", {8'd0, bus_req}, 9'd1);
        tick(1);
        chk("rd2_again_rm_bus", bus, 9'b01_010_0000);
        tick(2);

        // address 4 dirty, snoop read-miss plus CPU read 6 in the same cycle
        request(1'b1, 3'd4, 4'hC);
        tick(1);
        chk("wm4_bus", bus, 9'b10_100_1100);
        tick(2);
        snoop = 9'b01_100_0000;
        request(1'b0, 3'd6, 4'd0);
        snoop = 9'd0;
        chk("flush_arb_req", {8'd0, bus_req}, 9'd1);
        chk("flush_arb_bus", bus, 9'd0);
        tick(1);
        chk("flush_wb_bus", bus, 9'b11_100_1100);
        tick(1);
        chk("flush_idle_bus_req", {8'd0, bus_req}, 9'd0);
        chk("flush_no_ready", {8'd0, cpu_ready}, 9'd0);
        tick(1);
        chk("rd6_arb_req", {8'd0, bus_req}, 9'd1);
        tick(1);
        chk("rd6_rm_bus", bus, 9'b01_110_0000);
        tick(1);
        chk("rd6_ready", {8'd0, cpu_ready}, 9'd1);
        chk("rd6_rdata", {5'd0, cpu_rdata}, 9'h9);
        tick(1);

        // no grant: ARB holds, then reset aborts
        bus_gnt = 1'b0;
        request(1'b0, 3'd5, 4'd0);
        for (int k = 0; k < 10; k++) begin
            chk("stall_bus", bus, 9'd0);
            chk("stall_bus_req", {8'd0, bus_req}, 9'd1);
            tick(1);
        end
        reset_n = 1'b0;
        #1;
        chk("abort_bus_req", {8'd0, bus_req}, 9'd0);
        chk("abort_ready", {8'd0, cpu_ready}, 9'd0);
        chk("abort_rdata", {5'd0, cpu_rdata}, 9'd0);
        #1 reset_n = 1'b1;
        bus_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("post_abort_ready", {8'd0, cpu_ready}, 9'd0);
            chk("post_abort_bus_req", {8'd0, bus_req}, 9'd0);
        end

        // write hit on a modified line, then read it back
        request(1'b1, 3'd3, 4'h7);
        tick(1);
        chk("wm3b_bus", bus, 9'b10_011_0111);
        tick(2);
        request(1'b1, 3'd3, 4'h5);
        chk("whit_ready", {8'd0, cpu_ready}, 9'd1);
        chk("whit_bus_req", {8'd0, bus_req}, 9'd0);
        chk("whit_bus", bus, 9'd0);
        request(1'b0, 3'd3, 4'd0);
        chk("whit_read_ready", {8'd0, cpu_ready}, 9'd1);
        chk("whit_read_rdata", {5'd0, cpu_rdata}, 9'h5);
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
